// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes,
// funct codes, instruction classes and datapath mux selects.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'b000,
        S_ID  = 3'b001,
        S_EX  = 3'b010,
        S_MEM = 3'b011,
        S_WB  = 3'b100
    } state_t;

    typedef enum logic [3:0] {
        R_ALU, I_ALU, LW, SW, BEQ, BNE, J, JAL, JR, ILL
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    localparam logic [1:0] WSEL_RD = 2'b00;
    localparam logic [1:0] WSEL_RT = 2'b01;
    localparam logic [1:0] WSEL_RA = 2'b10;

    // Supported R-type ALU ops: add..nor, slt/sltu, and the six shifts.
    function automatic logic is_rtype_alu(input logic [5:0] fn);
        case (fn)
            6'b100000, 6'b100001, 6'b100010, 6'b100011,
            6'b100100, 6'b100101, 6'b100110, 6'b100111,
            6'b101010, 6'b101011,
            6'b000000, 6'b000010, 6'b000011,
            6'b000100, 6'b000110, 6'b000111: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_instr_class_dec.sv
// Combinational op/funct -> instruction class decode; jr is matched ahead
// of the R-type ALU set, and anything unrecognised maps to ILL.
module mc_instr_class_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output iclass_t    cls
);

    always_comb begin
        cls = ILL;
        case (op)
            OP_RTYPE: begin
                if (funct == FN_JR)
                    cls = JR;
                else if (is_rtype_alu(funct))
                    cls = R_ALU;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: cls = I_ALU;
            OP_LW:  cls = LW;
            OP_SW:  cls = SW;
            OP_BEQ: cls = BEQ;
            OP_BNE: cls = BNE;
            OP_J:   cls = J;
            OP_JAL: cls = JAL;
            default: cls = ILL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle IF/ID/EX/MEM/WB control for the 31-instruction MIPS core.
// Enables are gated by ena and rst; memory waits beyond MEM_WAIT_MAX pulse timeout.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_re,
    output logic       mem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       alu_src_b,
    output logic       rf_we,
    output logic [1:0] rf_waddr_sel,
    output logic [2:0] state,
    output logic       illegal,
    output logic       timeout
);

    localparam int CW = $clog2(MEM_WAIT_MAX + 1);

    state_t        st_q, st_d;
    iclass_t       cls_q, dec_cls;
    logic [CW-1:0] wait_cnt;
    logic          waiting, wait_hit, en;

    mc_instr_class_dec u_dec (
        .op    (op),
        .funct (funct),
        .cls   (dec_cls)
    );

    assign state    = st_q;
    assign en       = ena & ~rst;
    assign waiting  = ((st_q == S_IF) || (st_q == S_MEM)) && !mem_ready;
    assign wait_hit = (wait_cnt == CW'(MEM_WAIT_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            st_q <= S_IF;
        else if (ena)
            st_q <= st_d;
    end

    // Class is captured in ID so EX/MEM/WB no longer depend on IR timing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cls_q <= R_ALU;
        else if (ena && st_q == S_ID)
            cls_q <= dec_cls;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (ena) begin
            if (!waiting || wait_hit)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + CW'(1);
        end
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            S_IF:  if (mem_ready) st_d = S_ID;
            S_ID:  st_d = (dec_cls == ILL) ? S_IF : S_EX;
            S_EX: begin
                case (cls_q)
                    R_ALU, I_ALU, JAL: st_d = S_WB;
                    LW, SW:            st_d = S_MEM;
                    default:           st_d = S_IF;
                endcase
            end
            S_MEM: if (mem_ready) st_d = (cls_q == LW) ? S_WB : S_IF;
            S_WB:  st_d = S_IF;
            default: st_d = S_IF;
        endcase
    end

    always_comb begin
        mem_re       = 1'b0;
        mem_we       = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_PLUS4;
        alu_src_b    = 1'b0;
        rf_we        = 1'b0;
        rf_waddr_sel = WSEL_RD;
        illegal      = 1'b0;
        timeout      = en & waiting & wait_hit;
        case (st_q)
            S_IF: begin
                mem_re = en;
                ir_we  = en & mem_ready;
                pc_we  = en & mem_ready;
            end
            S_ID: illegal = en & (dec_cls == ILL);
            S_EX: begin
                case (cls_q)
                    I_ALU, LW, SW: alu_src_b = 1'b1;
                    BEQ: begin pc_we = en & zero;  pc_src = PC_BRANCH; end
                    BNE: begin pc_we = en & ~zero; pc_src = PC_BRANCH; end
                    J:   begin pc_we = en;         pc_src = PC_JUMP;   end
                    JR:  begin pc_we = en;         pc_src = PC_RS;     end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_re = en & (cls_q == LW);
                mem_we = en & (cls_q == SW);
            end
            S_WB: begin
                rf_we = en;
                case (cls_q)
                    I_ALU, LW: rf_waddr_sel = WSEL_RT;
                    JAL: begin
                        rf_waddr_sel = WSEL_RA;
                        pc_we        = en;
                        pc_src       = PC_JUMP;
                    end
                    default: rf_waddr_sel = WSEL_RD;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: walks each instruction class cycle by cycle
// against hand-computed state and control expectations.
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst, ena, zero, mem_ready;
    logic [5:0] op, funct;
    logic       mem_re, mem_we, ir_we, pc_we, alu_src_b, rf_we, illegal, timeout;
    logic [1:0] pc_src, rf_waddr_sel;
    logic [2:0] state;
    logic [4:0] en_vec;

    int checks = 0;
    int errors = 0;

    assign en_vec = {mem_re, mem_we, ir_we, pc_we, rf_we};

    mc_ctrl_fsm #(.MEM_WAIT_MAX(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .op           (op),
        .funct        (funct),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .mem_re       (mem_re),
        .mem_we       (mem_we),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .alu_src_b    (alu_src_b),
        .rf_we        (rf_we),
        .rf_waddr_sel (rf_waddr_sel),
        .state        (state),
        .illegal      (illegal),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        #1;
        checks++;
        if (state !== 3'b000) begin errors++; $display("FAIL reset_state got=%b exp=000", state); end
        checks++;
        if ({en_vec, pc_src, alu_src_b, rf_waddr_sel, illegal, timeout} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs en=%b pc_src=%b alu_b=%b wsel=%b ill=%b to=%b exp all 0",
                     en_vec, pc_src, alu_src_b, rf_waddr_sel, illegal, timeout);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (en_vec !== 5'b10000) begin errors++; $display("FAIL reset_release_if en=%b exp=10000", en_vec); end
    endtask

    task automatic test_addu;
        op = 6'b000000; funct = 6'b100001; mem_ready = 1'b1;
        #1;
        checks++;
        if ({state, en_vec} !== {3'b000, 5'b10110}) begin errors++; $display("FAIL addu_if state=%b en=%b exp=000/10110", state, en_vec); end
        tick;
        checks++;
        if ({state, en_vec, illegal} !== {3'b001, 5'b00000, 1'b0}) begin errors++; $display("FAIL addu_id state=%b en=%b ill=%b", state, en_vec, illegal); end
        tick;
        checks++;
        if ({state, alu_src_b, en_vec} !== {3'b010, 1'b0, 5'b00000}) begin errors++; $display("FAIL addu_ex state=%b alu_b=%b en=%b", state, alu_src_b, en_vec); end
        tick;
        checks++;
        if ({state, en_vec, rf_waddr_sel} !== {3'b100, 5'b00001, 2'b00}) begin errors++; $display("FAIL addu_wb state=%b en=%b wsel=%b exp=100/00001/00", state, en_vec, rf_waddr_sel); end
        tick;
        checks++;
        if (state !== 3'b000) begin errors++; $display("FAIL addu_back_if state=%b exp=000", state); end
    endtask

    task automatic test_reset_in_wb;
        op = 6'b000000; funct = 6'b100001; mem_ready = 1'b1;
        tick; tick; tick;
        checks++;
        if ({state, rf_we} !== {3'b100, 1'b1}) begin errors++; $display("FAIL rstwb_pre state=%b rf_we=%b exp=100/1", state, rf_we); end
        rst = 1'b1; mem_ready = 1'b0;
        #1;
        checks++;
        if ({state, en_vec} !== {3'b000, 5'b00000}) begin errors++; $display("FAIL rstwb_async state=%b en=%b exp=000/00000", state, en_vec); end
        @(posedge clk);
        #1;
        checks++;
        if ({state, en_vec} !== {3'b000, 5'b00000}) begin errors++; $display("FAIL rstwb_edge state=%b en=%b exp=000/00000", state, en_vec); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({state, en_vec} !== {3'b000, 5'b10000}) begin errors++; $display("FAIL rstwb_release state=%b en=%b exp=000/10000", state, en_vec); end
    endtask

    task automatic test_ena;
        op = 6'b000000; funct = 6'b100001; mem_ready = 1'b1; ena = 1'b0;
        #1;
        checks++;
        if (en_vec !== 5'b00000) begin errors++; $display("FAIL ena_off_en en=%b exp=00000", en_vec); end
        tick;
        checks++;
        if (state !== 3'b000) begin errors++; $display("FAIL ena_off_hold state=%b exp=000", state); end
        ena = 1'b1;
        tick; tick; tick; tick;
        checks++;
        if (state !== 3'b000) begin errors++; $display("FAIL ena_resume state=%b exp=000", state); end
    endtask

    task automatic test_lw;
        op = 6'b100011; mem_ready = 1'b1;
        #1;
        tick;
        mem_ready = 1'b0;
        tick;
        checks++;
        if ({state, alu_src_b} !== {3'b010, 1'b1}) begin errors++; $display("FAIL lw_ex state=%b alu_b=%b exp=010/1", state, alu_src_b); end
        tick;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({state, en_vec} !== {3'b011, 5'b10000}) begin errors++; $display("FAIL lw_mem_wait%0d state=%b en=%b exp=011/10000", i, state, en_vec); end
            tick;
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({state, mem_re} !== {3'b011, 1'b1}) begin errors++; $display("FAIL lw_mem_ready state=%b re=%b", state, mem_re); end
        tick;
        checks++;
        if ({state, en_vec, rf_waddr_sel} !== {3'b100, 5'b00001, 2'b01}) begin errors++; $display("FAIL lw_wb_cycle8 state=%b en=%b wsel=%b exp=100/00001/01", state, en_vec, rf_waddr_sel); end
        tick;
        checks++;
        if (state !== 3'b000) begin errors++; $display("FAIL lw_back_if state=%b", state); end
    endtask

    task automatic test_sw;
        op = 6'b101011; mem_ready = 1'b1;
        #1;
        tick; tick;
        checks++;
        if ({state, alu_src_b} !== {3'b010, 1'b1}) begin errors++; $display("FAIL sw_ex state=%b alu_b=%b", state, alu_src_b); end
        mem_ready = 1'b0;
        tick;
        checks++;
        if ({state, en_vec} !== {3'b011, 5'b01000}) begin errors++; $display("FAIL sw_mem_wait state=%b en=%b exp=011/01000", state, en_vec); end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (en_vec !== 5'b01000) begin errors++; $display("FAIL sw_mem_ready en=%b exp=01000", en_vec); end
        tick;
        checks++;
        if ({state, rf_we} !== {3'b000, 1'b0}) begin errors++; $display("FAIL sw_back_if state=%b rf_we=%b", state, rf_we); end
    endtask

    task automatic test_jal;
        op = 6'b000011; mem_ready = 1'b1;
        #1;
        tick; tick;
        checks++;
        if ({state, en_vec} !== {3'b010, 5'b00000}) begin errors++; $display("FAIL jal_ex state=%b en=%b", state, en_vec); end
        tick;
        checks++;
        if ({state, en_vec, pc_src, rf_waddr_sel} !== {3'b100, 5'b00011, 2'b10, 2'b10}) begin
            errors++;
            $display("FAIL jal_wb state=%b en=%b pc_src=%b wsel=%b exp=100/00011/10/10", state, en_vec, pc_src, rf_waddr_sel);
        end
        tick;
        checks++;
        if (state !== 3'b000) begin errors++; $display("FAIL jal_back_if state=%b", state); end
    endtask

    task automatic test_beq(input logic zv);
        op = 6'b000100; mem_ready = 1'b1; zero = zv;
        #1;
        tick; tick;
        checks++;
        if ({state, pc_we, pc_src, rf_we} !== {3'b010, zv, 2'b01, 1'b0}) begin
            errors++;
            $display("FAIL beq_ex_z%0d state=%b pc_we=%b pc_src=%b rf_we=%b", zv, state, pc_we, pc_src, rf_we);
        end
        tick;
        checks++;
        if ({state, rf_we} !== {3'b000, 1'b0}) begin errors++; $display("FAIL beq_back_if_z%0d state=%b rf_we=%b", zv, state, rf_we); end
        zero = 1'b0;
    endtask

    task automatic test_jumps;
        op = 6'b000000; funct = 6'b001000; mem_ready = 1'b1;
        #1;
        tick; tick;
        checks++;
        if ({state, pc_we, pc_src} !== {3'b010, 1'b1, 2'b11}) begin errors++; $display("FAIL jr_ex state=%b pc_we=%b pc_src=%b exp=010/1/11", state, pc_we, pc_src); end
        tick;
        op = 6'b000010;
        tick; tick;
        checks++;
        if ({state, pc_we, pc_src} !== {3'b010, 1'b1, 2'b10}) begin errors++; $display("FAIL j_ex state=%b pc_we=%b pc_src=%b exp=010/1/10", state, pc_we, pc_src); end
        tick;
        checks++;
        if (state !== 3'b000) begin errors++; $display("FAIL j_back_if state=%b", state); end
    endtask

    task automatic test_illegal;
        op = 6'b111111; mem_ready = 1'b1;
        #1;
        tick;
        checks++;
        if ({state, illegal, en_vec} !== {3'b001, 1'b1, 5'b00000}) begin errors++; $display("FAIL ill_op_id state=%b ill=%b en=%b", state, illegal, en_vec); end
        tick;
        checks++;
        if ({state, illegal} !== {3'b000, 1'b0}) begin errors++; $display("FAIL ill_op_next state=%b ill=%b exp=000/0", state, illegal); end
        op = 6'b000000; funct = 6'b001001;
        tick;
        checks++;
        if ({state, illegal} !== {3'b001, 1'b1}) begin errors++; $display("FAIL ill_funct_id state=%b ill=%b", state, illegal); end
        tick;
        checks++;
        if (state !== 3'b000) begin errors++; $display("FAIL ill_funct_next state=%b", state); end
    endtask

    task automatic test_timeout;
        int pulses = 0;
        int early  = 0;
        op = 6'b000010; mem_ready = 1'b0;
        #1;
        for (int i = 1; i <= 16; i++) begin
            checks++;
            if ({state, mem_re} !== {3'b000, 1'b1}) begin errors++; $display("FAIL to_wait%0d state=%b re=%b exp=000/1", i, state, mem_re); end
            if (timeout === 1'b1) begin
                pulses++;
                if (i <= 14) early++;
            end
            tick;
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL to_pulse_count got=%0d exp=1", pulses); end
        checks++;
        if (early != 0) begin errors++; $display("FAIL to_early_pulse got=%0d exp=0", early); end
        mem_ready = 1'b1;
        #1;
        tick; tick; tick;
        checks++;
        if ({state, timeout} !== {3'b000, 1'b0}) begin errors++; $display("FAIL to_recover state=%b to=%b", state, timeout); end
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        test_reset;
        test_addu;
        test_reset_in_wb;
        test_ena;
        test_lw;
        test_sw;
        test_jal;
        test_beq(1'b1);
        test_beq(1'b0);
        test_jumps;
        test_illegal;
        test_timeout;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
